pool_stream_unit: RTL and testbench
===================================

# pool_stream_unit

Parametrised streaming pooling engine that replaces the fixed 2×2, single-channel max comparator chain. It accepts a raster-ordered feature map with `CH` channels per beat over a valid/ready handshake. It reduces non-overlapping K×K windows by max or by average, and emits one pooled pixel (all channels) per window. It sits between the convolution/activation output stage and the next layer's input buffer.

## Interface
- `DATA_W`, 8: signed element width, input and output.
- `CH`, 4: channels per beat, processed in parallel lanes.
- `K`, 2: window size and stride; legal values are 2 or 4.
- `IMG_W`, 28: input width in pixels; must be a multiple of `K`.
- `IMG_H`, 28: input height in pixels; must be a multiple of `K`.
- `clk  in  1  clock.`
- `rst  in  1  synchronous, active-high reset.`
- `start  in  1  frame start pulse; ignored unless the block is in IDLE.`
- `mode  in  1  0 = max, 1 = average; sampled on the accepted start.`
- `in_valid  in  1  input beat valid.`
- `in_ready  out  1  input beat accepted when in_valid && in_ready.`
- `in_data  in  CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W].`
- `out_valid  out  1  pooled beat valid.`
- `out_ready  in  1  downstream accept.`
- `out_data  out  CH*DATA_W  pooled beat, same packing as in_data.`
- `busy  out  1  high in RUN and DRAIN.`
- `done  out  1  one-cycle pulse when the last pooled beat is accepted.`

## Operation
- FSM states and transitions:
  - IDLE → RUN on `start`; `mode` is latched and the col/row counters clear.
  - RUN → DRAIN after the `IMG_W*IMG_H`-th input beat is accepted.
  - DRAIN → IDLE once `out_valid && out_ready`; `done` pulses in the cycle after that handshake.
- `in_ready` = (state == RUN) && (!out_valid || out_ready). It is 0 in IDLE and DRAIN.
- Each lane holds a horizontal accumulator (`hacc`). It loads on `col%K==0`, otherwise combines with the incoming element.
- Row buffer: `IMG_W/K` entries × `CH` × `ACC_W`, indexed by `col/K`.
  - When `col%K==K-1` and `row%K==0`, the entry is written with the combined `hacc`.
  - For any other row it is combined with the stored entry.
  - When `row%K==K-1`, the combined result goes to the output register instead.
- Combine rule:
  - Max mode: signed maximum.
  - Average mode: signed sum.
- `ACC_W` = `DATA_W + 2*log2(K)`, so no overflow is possible.
- Output conversion:
  - Max mode: the low `DATA_W` bits (exact).
  - Average mode: the sum arithmetic-shifted right by `2*log2(K)`, i.e. floor toward −∞, e.g. sum −5 over 4 gives −2.
- Counters:
  - `col` wraps `IMG_W-1` → 0 and increments `row`.
  - `row` wraps at `IMG_H-1`, which coincides with the end of the frame.
- Row buffer contents are never reset; the `row%K==0` write always overwrites them before use.
- `mode` changes during RUN have no effect.

## Timing
- Reset values: state IDLE, `in_ready` 0, `out_valid` 0, `out_data` 0, `busy` 0, `done` 0, counters 0, `hacc` 0.
- Latency: `out_valid` rises the cycle after the beat completing a window (`col%K==K-1`, `row%K==K-1`) is accepted.
- Output register:
  - Holds `out_data` stable while `out_valid && !out_ready`.
  - Back-to-back windows are never adjacent (K ≥ 2 columns apart), so a single register suffices.
- Throughput: 1 input beat per cycle while `out_ready` is high.
- Simultaneous `out_ready` handshake and window completion in one cycle: the old beat retires and the new beat loads; no bubble.
- Reset mid-frame: abort immediately, return to IDLE, drop any pending output. The next `start` begins a clean frame.
- `start` asserted in RUN or DRAIN is ignored. `start` in the same cycle as `rst` is ignored.

## Structure
- `pool_pkg` contains:
  - `pool_mode_e` (POOL_MAX = 0, POOL_AVG = 1).
  - `pool_state_e` (IDLE, RUN, DRAIN).
  - a `clog2`-based `ACC_W` helper function.
- One sub-module, `pool_lane`, instantiated `CH` times:
  - combine function, `hacc` register, final conversion;
  - the row buffer slice for its lane.
- The top level owns the FSM, counters, handshake and output register.
- Elaboration-time assertions check that `K` ∈ {2, 4}, `IMG_W%K==0` and `IMG_H%K==0`.

## Test plan
- Max, K=2, CH=1, 4×4 image with values 0..15 raster-ordered → outputs 5, 7, 13, 15 in order; then `done` pulses once.
- Average, K=2, window {−1, −2, −1, −1} (sum −5) → −2. Window {127, 127, 127, 127} → 127, with no overflow.
- Max, K=4, CH=4, 8×8 image, each lane an independent random pattern → 4 beats matching the reference model per lane.
- Backpressure with `out_ready` held low 10 cycles at the first output → `out_data` stable and `in_ready` low on the next window-completing beat. No data is lost and the final sequence is unchanged.
- Assert `rst` halfway through a frame, then restart with mode = average → `out_valid` 0 the cycle after reset; the new frame produces correct averages unaffected by stale row-buffer contents.
- `start` pulsed during RUN and `mode` toggled mid-frame → no restart, and the latched mode governs the entire frame.

Source files
------------

// File: rtl/pool_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pool_pkg                                                  |
// | Brief    : Shared types and helpers for the streaming pooling engine |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
package pool_pkg;

   typedef enum logic {
      POOL_MAX = 1'b0,
      POOL_AVG = 1'b1
   } pool_mode_e;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } pool_state_e;

   // Accumulator width: a KxK sum of DATA_W-bit signed values never overflows
   function automatic int acc_w(input int data_w, input int k);
      return data_w + 2 * $clog2(k);
   endfunction

endpackage
`default_nettype wire

// File: rtl/pool_lane.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pool_lane                                                 |
// | Brief    : One channel of the pooling engine: horizontal accumulator,|
// |            row-buffer slice and final max/average conversion         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pool_lane
   import pool_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int K      = 2,
   parameter int IMG_W  = 28,
   parameter int IDX_W  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  pool_mode_e        i_mode,
   input  logic              i_beat,
   input  logic              i_col_first,
   input  logic              i_col_last,
   input  logic              i_row_first,
   input  logic              i_row_last,
   input  logic [IDX_W-1:0]  i_idx,
   input  logic [DATA_W-1:0] i_elem,
   output logic [DATA_W-1:0] o_result
);

   localparam int c_ACC_W = acc_w(DATA_W, K);
   localparam int c_SH    = 2 * $clog2(K);
   localparam int c_NWIN  = IMG_W / K;

   typedef logic signed [c_ACC_W-1:0] acc_t;

   function automatic acc_t combine(input pool_mode_e m, input acc_t a, input acc_t b);
      if (m == POOL_AVG) begin
         return a + b;
      end
      return (a > b) ? a : b;
   endfunction

   acc_t r_hacc;
   acc_t r_rowbuf [c_NWIN];
   acc_t w_elem;
   acc_t w_hacc_next;
   acc_t w_vert;
   acc_t w_shift;

   // Horizontal combine, vertical combine with the stored partial row, and conversion
   always_comb begin
      w_elem      = {{(c_ACC_W-DATA_W){i_elem[DATA_W-1]}}, i_elem};
      w_hacc_next = i_col_first ? w_elem : combine(i_mode, r_hacc, w_elem);
      w_vert      = combine(i_mode, r_rowbuf[i_idx], w_hacc_next);
      w_shift     = w_vert >>> c_SH;
      o_result    = (i_mode == POOL_AVG) ? w_shift[DATA_W-1:0] : w_vert[DATA_W-1:0];
   end

   // Horizontal accumulator tracks every accepted beat
   always_ff @(posedge clk) begin
      if (rst) begin
         r_hacc <= '0;
      end else if (i_beat) begin
         r_hacc <= w_hacc_next;
      end
   end

   // Row buffer: first window row overwrites, middle rows combine; never reset
   always_ff @(posedge clk) begin
      if (i_beat && i_col_last && !i_row_last) begin
         r_rowbuf[i_idx] <= i_row_first ? w_hacc_next : w_vert;
      end
   end

endmodule
`default_nettype wire

// File: rtl/pool_stream_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : pool_stream_unit                                          |
// | Brief    : Streaming KxK max/average pooling over CH parallel lanes  |
// |            with valid/ready handshakes on both sides                 |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module pool_stream_unit
   import pool_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int CH     = 4,
   parameter int K      = 2,
   parameter int IMG_W  = 28,
   parameter int IMG_H  = 28
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic                 mode,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [CH*DATA_W-1:0] in_data,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [CH*DATA_W-1:0] out_data,
   output logic                 busy,
   output logic                 done
);

   localparam int c_LOGK  = $clog2(K);
   localparam int c_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int c_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int c_NWIN  = IMG_W / K;
   localparam int c_IDX_W = (c_NWIN > 1) ? $clog2(c_NWIN) : 1;
   localparam logic [c_COL_W-1:0] c_COL_LAST = c_COL_W'(IMG_W - 1);
   localparam logic [c_ROW_W-1:0] c_ROW_LAST = c_ROW_W'(IMG_H - 1);
   localparam logic [c_LOGK-1:0]  c_PH_LAST  = c_LOGK'(K - 1);

   generate
      if (K != 2 && K != 4) begin : g_bad_k
         $error("pool_stream_unit: K must be 2 or 4");
      end
      if ((IMG_W % K) != 0) begin : g_bad_w
         $error("pool_stream_unit: IMG_W must be a multiple of K");
      end
      if ((IMG_H % K) != 0) begin : g_bad_h
         $error("pool_stream_unit: IMG_H must be a multiple of K");
      end
   endgenerate

   pool_state_e          r_state;
   pool_mode_e           r_mode;
   logic [c_COL_W-1:0]   r_col;
   logic [c_ROW_W-1:0]   r_row;
   logic                 w_beat;
   logic                 w_col_first;
   logic                 w_col_last;
   logic                 w_row_first;
   logic                 w_row_last;
   logic                 w_win_done;
   logic                 w_frame_end;
   logic [c_IDX_W-1:0]   w_idx;
   logic [CH*DATA_W-1:0] w_pooled;

   // Handshake and window-position decode
   always_comb begin
      in_ready    = (r_state == RUN) && (!out_valid || out_ready);
      busy        = (r_state != IDLE);
      w_beat      = in_valid && in_ready;
      w_col_first = (r_col[c_LOGK-1:0] == '0);
      w_col_last  = (r_col[c_LOGK-1:0] == c_PH_LAST);
      w_row_first = (r_row[c_LOGK-1:0] == '0);
      w_row_last  = (r_row[c_LOGK-1:0] == c_PH_LAST);
      w_idx       = c_IDX_W'(r_col >> c_LOGK);
      w_win_done  = w_beat && w_col_last && w_row_last;
      w_frame_end = w_beat && (r_col == c_COL_LAST) && (r_row == c_ROW_LAST);
   end

   generate
      for (genvar g = 0; g < CH; g++) begin : g_lane
         pool_lane #(
            .DATA_W (DATA_W),
            .K      (K),
            .IMG_W  (IMG_W),
            .IDX_W  (c_IDX_W)
         ) u_lane (
            .clk         (clk),
            .rst         (rst),
            .i_mode      (r_mode),
            .i_beat      (w_beat),
            .i_col_first (w_col_first),
            .i_col_last  (w_col_last),
            .i_row_first (w_row_first),
            .i_row_last  (w_row_last),
            .i_idx       (w_idx),
            .i_elem      (in_data[g*DATA_W +: DATA_W]),
            .o_result    (w_pooled[g*DATA_W +: DATA_W])
         );
      end
   endgenerate

   // Frame FSM, raster counters and the single-entry output register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_mode    <= POOL_MAX;
         r_col     <= '0;
         r_row     <= '0;
         out_valid <= 1'b0;
         out_data  <= '0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            IDLE: begin
               if (start) begin
                  r_state <= RUN;
                  r_mode  <= pool_mode_e'(mode);
                  r_col   <= '0;
                  r_row   <= '0;
               end
            end
            RUN: begin
               if (w_frame_end) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (out_valid && out_ready) begin
                  r_state <= IDLE;
                  done    <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase

         if (w_beat) begin
            if (r_col == c_COL_LAST) begin
               r_col <= '0;
               r_row <= (r_row == c_ROW_LAST) ? '0 : r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end

         // A retiring beat and a new window can coincide; the new one wins
         if (w_win_done) begin
            out_valid <= 1'b1;
            out_data  <= w_pooled;
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_pool_stream_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_pool_stream_unit                                       |
// | Brief    : Scoreboard bench for pool_stream_unit (K=2 4x4, K=4 8x8)  |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
module tb_pool_stream_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        start_a, mode_a, in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a, done_a;
   logic [31:0] in_data_a, out_data_a;
   logic        start_b, mode_b, in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b, done_b;
   logic [31:0] in_data_b, out_data_b;

   pool_stream_unit #(.DATA_W(8), .CH(4), .K(2), .IMG_W(4), .IMG_H(4)) u_dut_a (
      .clk(clk), .rst(rst), .start(start_a), .mode(mode_a),
      .in_valid(in_valid_a), .in_ready(in_ready_a), .in_data(in_data_a),
      .out_valid(out_valid_a), .out_ready(out_ready_a), .out_data(out_data_a),
      .busy(busy_a), .done(done_a)
   );

   pool_stream_unit #(.DATA_W(8), .CH(4), .K(4), .IMG_W(8), .IMG_H(8)) u_dut_b (
      .clk(clk), .rst(rst), .start(start_b), .mode(mode_b),
      .in_valid(in_valid_b), .in_ready(in_ready_b), .in_data(in_data_b),
      .out_valid(out_valid_b), .out_ready(out_ready_b), .out_data(out_data_b),
      .busy(busy_b), .done(done_b)
   );

   int          tests = 0;
   int          fails = 0;
   int          done_cnt_a = 0;
   int          done_cnt_b = 0;
   bit          bp_arm = 1'b0;
   logic [31:0] pix [64];
   logic [31:0] q_a [$];
   logic [31:0] q_b [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Reference pooling over pix[] in raster order, one packed result per window
   task automatic model(input int k, input int w, input int h, input bit avg,
                        output logic [31:0] res [16], output int n);
      int acc, q, v;
      logic signed [7:0] e;
      logic [31:0] beat;
      n = 0;
      for (int wr = 0; wr < h / k; wr++) begin
         for (int wc = 0; wc < w / k; wc++) begin
            beat = '0;
            for (int c = 0; c < 4; c++) begin
               acc = avg ? 0 : -1000;
               for (int dy = 0; dy < k; dy++) begin
                  for (int dx = 0; dx < k; dx++) begin
                     e = pix[(wr*k + dy)*w + wc*k + dx][c*8 +: 8];
                     v = e;
                     if (avg) acc += v;
                     else if (v > acc) acc = v;
                  end
               end
               q = avg ? acc / (k*k) : acc;
               if (avg && (acc % (k*k) != 0) && acc < 0) q -= 1;
               beat[c*8 +: 8] = q[7:0];
            end
            res[n] = beat;
            n++;
         end
      end
   endtask

   task automatic randomize_pix();
      for (int i = 0; i < 64; i++) pix[i] = $urandom;
   endtask

   task automatic send_a(input logic [31:0] d);
      bit ok = 1'b0;
      @(negedge clk);
      in_valid_a = 1'b1;
      in_data_a  = d;
      for (int t = 0; t < 64 && !ok; t++) begin
         #4 ok = in_ready_a;
         @(posedge clk);
         if (!ok) @(negedge clk);
      end
      if (!ok) check("a_accept_timeout", 32'(ok), 32'd1);
   endtask

   task automatic send_b(input logic [31:0] d);
      bit ok = 1'b0;
      @(negedge clk);
      in_valid_b = 1'b1;
      in_data_b  = d;
      for (int t = 0; t < 64 && !ok; t++) begin
         #4 ok = in_ready_b;
         @(posedge clk);
         if (!ok) @(negedge clk);
      end
      if (!ok) check("b_accept_timeout", 32'(ok), 32'd1);
   endtask

   // twist_at >= 0: pulse start and flip mode alongside that beat
   task automatic frame_a(input bit avg, input int n_beats, input int twist_at);
      logic [31:0] res [16];
      int n;
      model(2, 4, 4, avg, res, n);
      if (n_beats == 16) for (int i = 0; i < n; i++) q_a.push_back(res[i]);
      done_cnt_a = 0;
      @(negedge clk);
      start_a = 1'b1;
      mode_a  = avg;
      @(negedge clk);
      start_a = 1'b0;
      for (int i = 0; i < n_beats; i++) begin
         if (i == twist_at) begin
            start_a = 1'b1;
            mode_a  = ~avg;
         end
         send_a(pix[i]);
         start_a = 1'b0;
      end
      @(negedge clk);
      in_valid_a = 1'b0;
   endtask

   task automatic frame_b(input bit avg);
      logic [31:0] res [16];
      int n;
      model(4, 8, 8, avg, res, n);
      for (int i = 0; i < n; i++) q_b.push_back(res[i]);
      done_cnt_b = 0;
      @(negedge clk);
      start_b = 1'b1;
      mode_b  = avg;
      @(negedge clk);
      start_b = 1'b0;
      for (int i = 0; i < 64; i++) send_b(pix[i]);
      @(negedge clk);
      in_valid_b = 1'b0;
   endtask

   task automatic finish_a(input string tag);
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         #3;
         if (!busy_a && q_a.size() == 0) break;
      end
      check({tag, "_busy_low"}, 32'(busy_a), 32'd0);
      check({tag, "_queue_empty"}, 32'(q_a.size()), 32'd0);
      @(negedge clk);
      check({tag, "_done_once"}, 32'(done_cnt_a), 32'd1);
   endtask

   task automatic finish_b(input string tag);
      for (int t = 0; t < 200; t++) begin
         @(negedge clk);
         #3;
         if (!busy_b && q_b.size() == 0) break;
      end
      check({tag, "_busy_low"}, 32'(busy_b), 32'd0);
      check({tag, "_queue_empty"}, 32'(q_b.size()), 32'd0);
      @(negedge clk);
      check({tag, "_done_once"}, 32'(done_cnt_b), 32'd1);
   endtask

   // Output monitors: pop the scoreboard on every handshake
   initial forever begin
      @(negedge clk);
      #2;
      if (done_a === 1'b1) done_cnt_a++;
      if (out_valid_a === 1'b1 && out_ready_a === 1'b1) begin
         if (q_a.size() == 0) check("a_extra_beat", 32'(q_a.size()), 32'd1);
         else check("a_pooled", out_data_a, q_a.pop_front());
      end
   end

   initial forever begin
      @(negedge clk);
      #2;
      if (done_b === 1'b1) done_cnt_b++;
      if (out_valid_b === 1'b1 && out_ready_b === 1'b1) begin
         if (q_b.size() == 0) check("b_extra_beat", 32'(q_b.size()), 32'd1);
         else check("b_pooled", out_data_b, q_b.pop_front());
      end
   end

   // Downstream for A: when armed, stall the first pooled beat for 10 cycles
   initial begin
      logic [31:0] held;
      out_ready_a = 1'b1;
      forever begin
         @(negedge clk);
         if (bp_arm && out_valid_a === 1'b1) begin
            held        = out_data_a;
            bp_arm      = 1'b0;
            out_ready_a = 1'b0;
            for (int i = 0; i < 10; i++) begin
               @(negedge clk);
               #3;
               check("bp_hold_data", out_data_a, held);
               check("bp_in_ready_low", 32'(in_ready_a), 32'd0);
            end
            @(negedge clk);
            out_ready_a = 1'b1;
         end
      end
   end

   initial out_ready_b = 1'b1;

   initial begin
      rst = 1'b1;
      start_a = 1'b0; mode_a = 1'b0; in_valid_a = 1'b0; in_data_a = '0;
      start_b = 1'b0; mode_b = 1'b0; in_valid_b = 1'b0; in_data_b = '0;
      repeat (3) @(negedge clk);
      #3;
      check("rst_a_out_valid", 32'(out_valid_a), 32'd0);
      check("rst_a_in_ready",  32'(in_ready_a),  32'd0);
      check("rst_a_busy",      32'(busy_a),      32'd0);
      check("rst_a_done",      32'(done_a),      32'd0);
      check("rst_a_out_data",  out_data_a,       32'd0);
      check("rst_b_out_valid", 32'(out_valid_b), 32'd0);
      check("rst_b_in_ready",  32'(in_ready_b),  32'd0);
      check("rst_b_out_data",  out_data_b,       32'd0);
      @(negedge clk);
      rst = 1'b0;

      // Max, lane 0 carries 0..15 (expect 5, 7, 13, 15); other lanes random
      randomize_pix();
      for (int i = 0; i < 16; i++) pix[i][7:0] = 8'(i);
      frame_a(1'b0, 16, -1);
      finish_a("a_max_ramp");

      // Average: lane 0 windows {-1,-2,-1,-1} -> -2 and {127 x4} -> 127
      randomize_pix();
      pix[0][7:0] = 8'hFF; pix[1][7:0] = 8'hFE; pix[4][7:0] = 8'hFF; pix[5][7:0] = 8'hFF;
      pix[2][7:0] = 8'h7F; pix[3][7:0] = 8'h7F; pix[6][7:0] = 8'h7F; pix[7][7:0] = 8'h7F;
      frame_a(1'b1, 16, -1);
      finish_a("a_avg_edges");

      // Backpressure on the first pooled beat
      randomize_pix();
      bp_arm = 1'b1;
      frame_a(1'b0, 16, -1);
      finish_a("a_backpressure");

      // Abort mid-frame (start held with rst must be ignored), then a clean average frame
      randomize_pix();
      frame_a(1'b1, 5, -1);
      @(negedge clk);
      rst = 1'b1;
      start_a = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start_a = 1'b0;
      #3;
      check("abort_out_valid", 32'(out_valid_a), 32'd0);
      check("abort_busy", 32'(busy_a), 32'd0);
      randomize_pix();
      frame_a(1'b1, 16, -1);
      finish_a("a_after_abort");

      // Start pulse and mode flip mid-frame have no effect
      randomize_pix();
      frame_a(1'b0, 16, 7);
      finish_a("a_mode_latched");

      // K=4, 8x8, independent random lanes
      randomize_pix();
      frame_b(1'b0);
      finish_b("b_max");
      randomize_pix();
      frame_b(1'b1);
      finish_b("b_avg");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
